regfile_wb_sched: RTL and testbench
===================================

// Module: regfile_wb_sched
// PURPOSE
//  Write-back scheduler for the 32x32 register file's single write port.
//  Round-robin arbitrates NREQ write-back requesters (e.g. ALU, load unit, mul/div).
//  Drives the register file's RegWrite/Writeadd/WriteData from a registered stage.
//  Keeps a pending-write scoreboard that issue logic uses for RAW/WAW hazard checks.
// PARAMETERS
//  NREQ  2   number of write-back requesters (2..4)
//  DW    32  data width
//  AW    5   register address width (2**AW registers)
// PORTS
//  clk        in   1        clock, all state updates on rising edge
//  rst        in   1        synchronous reset, active-high
//  req_valid  in   NREQ     requester i has a write-back pending
//  req_addr   in   NREQ*AW  destination register, slice i = [i*AW +: AW]
//  req_data   in   NREQ*DW  write data, slice i = [i*DW +: DW]
//  req_ready  out  NREQ     one-hot grant; transfer when req_valid[i] & req_ready[i]
//  wr_hold    in   1        freeze write port: no grants this cycle
//  iss_valid  in   1        issue stage reserves a destination register
//  iss_rd     in   AW       register being reserved
//  iss_ready  out  1        reservation accepted this cycle
//  pending    out  2**AW    bit r=1: write to register r outstanding
//  RegWrite   out  1        register-file write enable (registered)
//  Writeadd   out  AW       register-file write address (registered)
//  WriteData  out  DW       register-file write data (registered)
// BEHAVIOUR
//  Reset: RegWrite=0, Writeadd=0, WriteData=0, pending=0, rr_ptr=0.
//   Reset mid-operation discards in-flight writes and reservations.
//  Arbitration: combinational round-robin from rr_ptr; first valid i scanning
//   rr_ptr, rr_ptr+1, ... (mod NREQ) gets req_ready[i]=1; all others 0.
//  - wr_hold=1 or rst=1: req_ready all 0, rr_ptr unchanged.
//  - On a grant to i: rr_ptr <= (i+1) mod NREQ. No grant: rr_ptr holds.
//  - req_ready never depends on req_data; at most one bit set per cycle.
//  Write stage (latency 1): on a transfer at edge N, after edge N RegWrite=1,
//   Writeadd=req_addr[i], WriteData=req_data[i] for exactly one cycle.
//  - No transfer: RegWrite <= 0; Writeadd/WriteData hold their last values.
//  - Address 0: transfer is accepted (ready=1) but RegWrite stays 0.
//  Scoreboard:
//  - iss_ready = (iss_rd==0) | ~pending[iss_rd]; combinational.
//  - Reserve: iss_valid & iss_ready & iss_rd!=0 -> pending[iss_rd] <= 1.
//  - Clear: a transfer to addr a != 0 -> pending[a] <= 0 at the same edge
//    RegWrite rises.
//  - Same-cycle reserve and clear of the same register: clear wins;
//    iss_ready is 0 for that register because its pending bit is set.
//  - Reserve and clear of different registers apply together.
//  - Write to a register with no pending bit is legal; pending is unaffected.
//  - pending[0] is constant 0.
//  No overflow or underflow is possible: one write slot per cycle, and one
//   outstanding reservation per register.
// TESTING
//  T1 rst=1 for 2 cycles with random inputs -> RegWrite=0, pending=0,
//     req_ready=0; after release, req_valid=01 -> grant to requester 0.
//  T2 NREQ=2, both valid for 4 cycles, addrs 3/4, data A/B -> ready 01,10,01,10;
//     RegWrite=1 each cycle from cycle 2 with Writeadd 3,4,3,4.
//  T3 req_addr=0, data=FFFF_FFFF, valid -> req_ready=1, RegWrite=0,
//     pending unchanged.
//  T4 issue rd=5 -> pending[5]=1; issue rd=5 again -> iss_ready=0; write-back
//     to 5 -> pending[5]=0 and RegWrite=1 after the same edge.
//  T5 wr_hold=1 for 3 cycles with both valid -> req_ready=0, RegWrite=0;
//     release -> grant follows the rr_ptr value held from before the hold.
//  T6 rst asserted the cycle after a transfer with pending[7]=1 ->
//     RegWrite=0 and pending=0 on the next cycle.

Source files
------------

// File: rtl/regfile_wb_sched_if.sv
// Interface for the register-file write-back scheduler.
// The master side (requesters and issue stage) drives requests and reservations.
// The slave side (the scheduler) returns grants, reservation status, the
// pending scoreboard and the registered register-file write port.
interface regfile_wb_sched_if #(
    parameter int NREQ = 2,
    parameter int DW   = 32,
    parameter int AW   = 5
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 wr_hold;
    logic                 iss_valid;
    logic [AW-1:0]        iss_rd;
    logic                 iss_ready;
    logic [(1<<AW)-1:0]   pending;
    logic                 RegWrite;
    logic [AW-1:0]        Writeadd;
    logic [DW-1:0]        WriteData;

    modport master (
        output req_valid, req_addr, req_data, wr_hold, iss_valid, iss_rd,
        input  req_ready, iss_ready, pending, RegWrite, Writeadd, WriteData
    );

    modport slave (
        input  req_valid, req_addr, req_data, wr_hold, iss_valid, iss_rd,
        output req_ready, iss_ready, pending, RegWrite, Writeadd, WriteData
    );
endinterface

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: round-robin grant of NREQ requesters onto the single
// register-file write port, plus a pending-write scoreboard for hazard checks.
// Latency: grant is combinational, RegWrite/Writeadd/WriteData registered (1 cycle).
// Backpressure: req_ready is a one-hot grant, all zero under wr_hold or rst;
// iss_ready drops while the requested destination already has a write pending.
// Ports: clk, rst (synchronous, active-high), bus (slave modport of
// regfile_wb_sched_if carrying requests, grants, issue, scoreboard, write port).
module regfile_wb_sched #(
    parameter int NREQ = 2,
    parameter int DW   = 32,
    parameter int AW   = 5
) (
    input logic               clk,
    input logic               rst,
    regfile_wb_sched_if.slave bus
);
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int NREG = 1 << AW;

    logic [PW-1:0]   rr_q, rr_d;
    logic [NREQ-1:0] grant;
    logic            gnt_any;
    logic [PW-1:0]   gnt_idx;
    logic [AW-1:0]   gnt_addr;
    logic [DW-1:0]   gnt_data;

    logic            regwrite_q, regwrite_d;
    logic [AW-1:0]   writeadd_q, writeadd_d;
    logic [DW-1:0]   writedata_q, writedata_d;
    logic [NREG-1:0] pending_q, pending_d;

    logic            iss_ready;
    logic            reserve;

    // Round-robin scan starting at rr_ptr; first valid requester wins.
    always_comb begin : arb
        int idx;
        idx     = 0;
        grant   = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (!rst && !bus.wr_hold) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (int'(rr_q) + k) % NREQ;
                if (!gnt_any && bus.req_valid[idx]) begin
                    grant[idx] = 1'b1;
                    gnt_idx    = PW'(idx);
                    gnt_any    = 1'b1;
                end
            end
        end
    end

    assign gnt_addr = bus.req_addr[int'(gnt_idx)*AW +: AW];
    assign gnt_data = bus.req_data[int'(gnt_idx)*DW +: DW];

    // Register 0 is hardwired, so it never needs a reservation.
    assign iss_ready = (bus.iss_rd == '0) | ~pending_q[bus.iss_rd];
    assign reserve   = bus.iss_valid & iss_ready & (bus.iss_rd != '0);

    always_comb begin : nxt
        rr_d        = rr_q;
        regwrite_d  = 1'b0;
        writeadd_d  = writeadd_q;
        writedata_d = writedata_q;
        pending_d   = pending_q;

        if (gnt_any) begin
            rr_d        = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
            // Writes to register 0 are accepted but never reach the file.
            regwrite_d  = (gnt_addr != '0);
            writeadd_d  = gnt_addr;
            writedata_d = gnt_data;
        end

        if (reserve) begin
            pending_d[bus.iss_rd] = 1'b1;
        end
        // Clear is applied after reserve so it wins on a same-register collision.
        if (gnt_any && gnt_addr != '0) begin
            pending_d[gnt_addr] = 1'b0;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q        <= '0;
            regwrite_q  <= 1'b0;
            writeadd_q  <= '0;
            writedata_q <= '0;
            pending_q   <= '0;
        end else begin
            rr_q        <= rr_d;
            regwrite_q  <= regwrite_d;
            writeadd_q  <= writeadd_d;
            writedata_q <= writedata_d;
            pending_q   <= pending_d;
        end
    end

    assign bus.req_ready = grant;
    assign bus.iss_ready = iss_ready;
    assign bus.pending   = pending_q;
    assign bus.RegWrite  = regwrite_q;
    assign bus.Writeadd  = writeadd_q;
    assign bus.WriteData = writedata_q;
endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched (NREQ=2, DW=32, AW=5).
// Inputs change 1ns after a rising edge; registered outputs are checked right
// after that edge, combinational outputs 1ns after the inputs change.
module tb_regfile_wb_sched;
    localparam int NREQ = 2;
    localparam int DW   = 32;
    localparam int AW   = 5;

    localparam logic [31:0] DA = 32'hAAAA_0001;
    localparam logic [31:0] DB = 32'hBBBB_0002;
    localparam logic [31:0] DC = 32'hCCCC_0003;
    localparam logic [31:0] DD = 32'hDDDD_0004;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    regfile_wb_sched_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bus ();

    regfile_wb_sched #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [1:0] v,
                           input logic [4:0] a0, input logic [31:0] d0,
                           input logic [4:0] a1, input logic [31:0] d1);
        bus.req_valid = v;
        bus.req_addr  = {a1, a0};
        bus.req_data  = {d1, d0};
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // T1: reset with random inputs
        rst           = 1'b1;
        bus.req_valid = 2'($urandom);
        bus.req_addr  = 10'($urandom);
        bus.req_data  = 64'({$urandom, $urandom});
        bus.wr_hold   = 1'($urandom);
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'($urandom_range(1, 31));
        settle();
        chk("t1_ready_in_rst", 64'(bus.req_ready), 64'd0);
        tick();
        bus.req_valid = 2'b11;
        settle();
        chk("t1_ready_in_rst2", 64'(bus.req_ready), 64'd0);
        tick();
        chk("t1_regwrite_rst", 64'(bus.RegWrite), 64'd0);
        chk("t1_pending_rst", 64'(bus.pending), 64'd0);
        chk("t1_writeadd_rst", 64'(bus.Writeadd), 64'd0);
        chk("t1_writedata_rst", 64'(bus.WriteData), 64'd0);

        rst           = 1'b0;
        bus.wr_hold   = 1'b0;
        bus.iss_valid = 1'b0;
        set_req(2'b01, 5'd1, DD, 5'd2, DC);
        settle();
        chk("t1_grant0", 64'(bus.req_ready), 64'b01);
        tick();                                  // rr -> 1
        chk("t1_regwrite", 64'(bus.RegWrite), 64'd1);
        chk("t1_writeadd", 64'(bus.Writeadd), 64'd1);
        // Move rr back to 0 with a lone grant to requester 1.
        set_req(2'b10, 5'd1, DD, 5'd2, DC);
        settle();
        chk("t1_grant1", 64'(bus.req_ready), 64'b10);
        tick();                                  // rr -> 0
        chk("t1_wdata1", 64'(bus.WriteData), 64'(DC));

        // T2: both valid, alternating grants
        set_req(2'b11, 5'd3, DA, 5'd4, DB);
        settle();
        chk("t2_ready_c1", 64'(bus.req_ready), 64'b01);
        tick();
        chk("t2_rw_c2", 64'(bus.RegWrite), 64'd1);
        chk("t2_wa_c2", 64'(bus.Writeadd), 64'd3);
        chk("t2_wd_c2", 64'(bus.WriteData), 64'(DA));
        chk("t2_ready_c2", 64'(bus.req_ready), 64'b10);
        tick();
        chk("t2_wa_c3", 64'(bus.Writeadd), 64'd4);
        chk("t2_wd_c3", 64'(bus.WriteData), 64'(DB));
        chk("t2_ready_c3", 64'(bus.req_ready), 64'b01);
        tick();
        chk("t2_wa_c4", 64'(bus.Writeadd), 64'd3);
        chk("t2_ready_c4", 64'(bus.req_ready), 64'b10);
        tick();                                  // rr -> 0
        chk("t2_rw_c5", 64'(bus.RegWrite), 64'd1);
        chk("t2_wa_c5", 64'(bus.Writeadd), 64'd4);
        set_req(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        tick();
        chk("t2_rw_idle", 64'(bus.RegWrite), 64'd0);
        chk("t2_wa_hold", 64'(bus.Writeadd), 64'd4);
        chk("t2_wd_hold", 64'(bus.WriteData), 64'(DB));

        // T3: write to register 0
        set_req(2'b01, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'd0);
        settle();
        chk("t3_ready", 64'(bus.req_ready), 64'b01);
        tick();                                  // rr -> 1
        chk("t3_regwrite", 64'(bus.RegWrite), 64'd0);
        chk("t3_pending", 64'(bus.pending), 64'd0);
        set_req(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);

        // T4: scoreboard reserve / clear
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd5;
        settle();
        chk("t4_iss_ready5", 64'(bus.iss_ready), 64'd1);
        tick();
        chk("t4_pending5", 64'(bus.pending), 64'(32'h0000_0020));
        chk("t4_iss_blocked5", 64'(bus.iss_ready), 64'd0);
        // Clear 5 via requester 1 while reserving 9.
        bus.iss_rd = 5'd9;
        set_req(2'b10, 5'd0, 32'd0, 5'd5, DC);
        settle();
        chk("t4_ready_wb5", 64'(bus.req_ready), 64'b10);
        chk("t4_iss_ready9", 64'(bus.iss_ready), 64'd1);
        tick();                                  // rr -> 0
        chk("t4_rw_wb5", 64'(bus.RegWrite), 64'd1);
        chk("t4_wa_wb5", 64'(bus.Writeadd), 64'd5);
        chk("t4_wd_wb5", 64'(bus.WriteData), 64'(DC));
        chk("t4_pending9", 64'(bus.pending), 64'(32'h0000_0200));
        // Same-cycle reserve and clear of 9: clear wins.
        set_req(2'b01, 5'd9, DD, 5'd0, 32'd0);
        settle();
        chk("t4_iss_blocked9", 64'(bus.iss_ready), 64'd0);
        tick();                                  // rr -> 1
        chk("t4_pending_clr9", 64'(bus.pending), 64'd0);
        chk("t4_wa_wb9", 64'(bus.Writeadd), 64'd9);
        set_req(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        bus.iss_rd = 5'd0;
        settle();
        chk("t4_iss_ready0", 64'(bus.iss_ready), 64'd1);
        tick();
        chk("t4_pending_r0", 64'(bus.pending), 64'd0);
        bus.iss_valid = 1'b0;

        // T5: write hold with rr_ptr = 1
        bus.wr_hold = 1'b1;
        set_req(2'b11, 5'd3, DA, 5'd4, DB);
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t5_ready_hold", 64'(bus.req_ready), 64'd0);
            tick();
            chk("t5_rw_hold", 64'(bus.RegWrite), 64'd0);
        end
        bus.wr_hold = 1'b0;
        settle();
        chk("t5_ready_release", 64'(bus.req_ready), 64'b10);
        tick();                                  // rr -> 0
        chk("t5_rw_release", 64'(bus.RegWrite), 64'd1);
        chk("t5_wa_release", 64'(bus.Writeadd), 64'd4);

        // T6: reset right after a transfer with pending[7] set
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd7;
        set_req(2'b01, 5'd3, DA, 5'd8, DB);
        tick();                                  // rr -> 1
        chk("t6_pending7", 64'(bus.pending), 64'(32'h0000_0080));
        chk("t6_rw_before", 64'(bus.RegWrite), 64'd1);
        bus.iss_valid = 1'b0;
        rst           = 1'b1;
        set_req(2'b10, 5'd3, DA, 5'd8, DB);
        settle();
        chk("t6_ready_rst", 64'(bus.req_ready), 64'd0);
        tick();
        chk("t6_rw_after", 64'(bus.RegWrite), 64'd0);
        chk("t6_pending_after", 64'(bus.pending), 64'd0);
        rst = 1'b0;
        set_req(2'b11, 5'd3, DA, 5'd8, DB);
        settle();
        chk("t6_rr_reset", 64'(bus.req_ready), 64'b01);
        tick();
        chk("t6_wa_post", 64'(bus.Writeadd), 64'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
